bcp_engine: RTL and testbench

BCP_ENGINE -- requirements
Module: bcp_engine

---
 rtl/bcp_engine_pkg.sv | 38 +++
 rtl/bcp_engine_clause_eval.sv | 53 +++++
 rtl/bcp_engine.sv | 197 +++++++++++++++++++
 tb/tb_bcp_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_engine_pkg.sv
// Shared types for the BCP engine: literal/pointer/node formats and FSM states.
// The end of an occurrence list is flagged by node.last, so no NULL pointer value exists.
package bcp_engine_pkg;

    localparam int LIT_IDX_MAX = 15;
    localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;
    localparam int DEPTH_MAX   = 16;
    localparam int PTR_W       = $clog2(DEPTH_MAX);

    typedef logic signed [LIT_W-1:0] lit_t;
    typedef logic [PTR_W-1:0]        ptr_t;

    typedef struct packed {
        lit_t lit0;
        lit_t lit1;
        lit_t lit2;
        ptr_t next;
        logic last;
    } node_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_EMIT,
        ST_HALT
    } state_t;

    // Variable index of a literal (its magnitude).
    function automatic logic [LIT_W-1:0] lit_var(lit_t l);
        return l[LIT_W-1] ? LIT_W'(-l) : LIT_W'(l);
    endfunction

    // Polarity of a literal: 1 = positive.
    function automatic logic lit_pos(lit_t l);
        return ~l[LIT_W-1];
    endfunction

endpackage

// File: rtl/bcp_engine_clause_eval.sv
// Combinational clause classifier: three literal slots against the assignment table.
module bcp_clause_eval
    import bcp_engine_pkg::*;
(
    input  logic [LIT_IDX_MAX:1] assigned,
    input  logic [LIT_IDX_MAX:1] value,
    input  lit_t                 lit0,
    input  lit_t                 lit1,
    input  lit_t                 lit2,
    output logic                 sat,
    output logic                 conflict,
    output logic                 unit,
    output lit_t                 unit_lit
);

    lit_t       slot [3];
    logic [1:0] n_unas;
    logic       slot_asg;
    logic       slot_val;

    // Classify each non-empty slot and count the unassigned ones.
    always_comb begin
        slot[0]  = lit0;
        slot[1]  = lit1;
        slot[2]  = lit2;
        sat      = 1'b0;
        n_unas   = 2'd0;
        unit_lit = '0;
        slot_asg = 1'b0;
        slot_val = 1'b0;
        for (int s = 0; s < 3; s++) begin
            slot_asg = 1'b0;
            slot_val = 1'b0;
            for (int k = 1; k <= LIT_IDX_MAX; k++) begin
                if (lit_var(slot[s]) == k[LIT_W-1:0]) begin
                    slot_asg = assigned[k];
                    slot_val = value[k];
                end
            end
            if (slot[s] != '0) begin
                if (!slot_asg) begin
                    n_unas   = n_unas + 2'd1;
                    unit_lit = slot[s];
                end else if (slot_val == lit_pos(slot[s])) begin
                    sat = 1'b1;
                end
            end
        end
        conflict = !sat && (n_unas == 2'd0);
        unit     = !sat && (n_unas == 2'd1);
    end

endmodule

// File: rtl/bcp_engine.sv
// Boolean constraint propagation engine: walks a literal's clause occurrence list,
// pushes implied literals and flags conflicts.
// Optional macro BCP_STATS_EN adds saturating visit/implication counters.
//
// state | meaning
// IDLE  | waiting for a unit literal from the arbiter
// WALK  | evaluating the clause node at cur_ptr, one per cycle
// EMIT  | offering the implied literal to the unit-clause queue
// HALT  | conflict seen, waiting for top2bcp_clear
module bcp_engine
    import bcp_engine_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int MAX_WALK = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  lit_t  ucarb2bcp_lit,
    input  logic  ucarb2bcp_lit_valid,
    output logic  bcp2ucarb_ready,
    input  ptr_t  clq2bcp_init_ptr,
    input  logic  clq2bcp_init_ptr_valid,
    output ptr_t  bcp2clq_cnf_idx,
    input  node_t clq2bcp_node_out,
    output lit_t  bcp2ucq_lit,
    output logic  bcp2ucq_valid,
    input  logic  ucq2bcp_ready,
    input  logic  top2bcp_clear,
    output logic  bcp2top_conflict
`ifdef BCP_STATS_EN
    ,
    output logic [31:0] bcp2top_nodes_visited,
    output logic [31:0] bcp2top_implications
`endif
);

    localparam int   WC_W      = (MAX_WALK > 1) ? $clog2(MAX_WALK) : 1;
    localparam logic [WC_W-1:0] WCNT_LAST = WC_W'(MAX_WALK - 1);
    // Pointers beyond the queue fold back to node 0 rather than aliasing.
    localparam ptr_t PTR_LAST  = ptr_t'(DEPTH - 1);

    state_t               state, state_nx;
    ptr_t                 cur_ptr, cur_ptr_nx;
    logic [WC_W-1:0]      walk_cnt, walk_cnt_nx;
    logic [LIT_IDX_MAX:1] assigned, assigned_nx;
    logic [LIT_IDX_MAX:1] value, value_nx;
    logic                 conflict, conflict_nx;
    lit_t                 emit_lit, emit_lit_nx;
    logic                 emit_end, emit_end_nx;
    logic                 ready_en;

    logic [LIT_IDX_MAX:1] lit_onehot;
    logic                 lit_clash;
    logic                 walk_end;
    ptr_t                 next_ptr;
    logic                 ev_sat, ev_conflict, ev_unit;
    lit_t                 ev_unit_lit;

    bcp_clause_eval u_eval (
        .assigned (assigned),
        .value    (value),
        .lit0     (clq2bcp_node_out.lit0),
        .lit1     (clq2bcp_node_out.lit1),
        .lit2     (clq2bcp_node_out.lit2),
        .sat      (ev_sat),
        .conflict (ev_conflict),
        .unit     (ev_unit),
        .unit_lit (ev_unit_lit)
    );

    assign bcp2ucarb_ready  = ready_en && (state == ST_IDLE) && !conflict;
    assign bcp2clq_cnf_idx  = cur_ptr;
    assign bcp2ucq_valid    = (state == ST_EMIT);
    assign bcp2ucq_lit      = emit_lit;
    assign bcp2top_conflict = conflict;

    // Decode the offered literal's variable and detect a polarity clash.
    always_comb begin
        lit_onehot = '0;
        for (int k = 1; k <= LIT_IDX_MAX; k++) begin
            lit_onehot[k] = (lit_var(ucarb2bcp_lit) == k[LIT_W-1:0]);
        end
        lit_clash = |(assigned & lit_onehot &
                      (value ^ {LIT_IDX_MAX{lit_pos(ucarb2bcp_lit)}}));
        walk_end  = clq2bcp_node_out.last || (walk_cnt == WCNT_LAST);
        next_ptr  = (clq2bcp_node_out.next > PTR_LAST) ? '0 : clq2bcp_node_out.next;
    end

    // Next-state and datapath updates; clear overrides everything.
    always_comb begin
        state_nx    = state;
        cur_ptr_nx  = cur_ptr;
        walk_cnt_nx = walk_cnt;
        assigned_nx = assigned;
        value_nx    = value;
        conflict_nx = conflict;
        emit_lit_nx = emit_lit;
        emit_end_nx = emit_end;
        if (top2bcp_clear) begin
            state_nx    = ST_IDLE;
            assigned_nx = '0;
            value_nx    = '0;
            conflict_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ucarb2bcp_lit_valid && bcp2ucarb_ready) begin
                        if (lit_clash) begin
                            conflict_nx = 1'b1;
                            state_nx    = ST_HALT;
                        end else begin
                            assigned_nx = assigned | lit_onehot;
                            value_nx    = lit_pos(ucarb2bcp_lit) ? (value | lit_onehot)
                                                                 : (value & ~lit_onehot);
                            if (clq2bcp_init_ptr_valid) begin
                                cur_ptr_nx  = clq2bcp_init_ptr;
                                walk_cnt_nx = '0;
                                state_nx    = ST_WALK;
                            end
                        end
                    end
                end
                ST_WALK: begin
                    if (ev_conflict) begin
                        conflict_nx = 1'b1;
                        state_nx    = ST_HALT;
                    end else begin
                        if (ev_unit && !ev_sat) begin
                            emit_lit_nx = ev_unit_lit;
                            emit_end_nx = walk_end;
                            state_nx    = ST_EMIT;
                        end else if (walk_end) begin
                            state_nx = ST_IDLE;
                        end
                        if (!walk_end) begin
                            cur_ptr_nx  = next_ptr;
                            walk_cnt_nx = walk_cnt + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (ucq2bcp_ready) begin
                        state_nx = emit_end ? ST_IDLE : ST_WALK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_ptr  <= '0;
            walk_cnt <= '0;
            assigned <= '0;
            value    <= '0;
            conflict <= 1'b0;
            emit_lit <= '0;
            emit_end <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_ptr  <= cur_ptr_nx;
            walk_cnt <= walk_cnt_nx;
            assigned <= assigned_nx;
            value    <= value_nx;
            conflict <= conflict_nx;
            emit_lit <= emit_lit_nx;
            emit_end <= emit_end_nx;
            ready_en <= 1'b1;
        end
    end

`ifdef BCP_STATS_EN
    // Saturating counters of evaluated nodes and completed implications.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcp2top_nodes_visited <= '0;
            bcp2top_implications  <= '0;
        end else if (top2bcp_clear) begin
            bcp2top_nodes_visited <= '0;
            bcp2top_implications  <= '0;
        end else begin
            if ((state == ST_WALK) && (bcp2top_nodes_visited != '1)) begin
                bcp2top_nodes_visited <= bcp2top_nodes_visited + 32'd1;
            end
            if ((state == ST_EMIT) && ucq2bcp_ready && (bcp2top_implications != '1)) begin
                bcp2top_implications <= bcp2top_implications + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bcp_engine.sv
// Directed and randomized bench for bcp_engine against a list-walking reference model.
module tb_bcp_engine;
    import bcp_engine_pkg::*;

    localparam int MAXW = 4;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    lit_t  lit = '0;
    logic  lit_valid = 1'b0;
    logic  ready;
    ptr_t  init_ptr = '0;
    logic  init_ptr_valid = 1'b0;
    ptr_t  cnf_idx;
    node_t node_out;
    lit_t  ucq_lit;
    logic  ucq_valid;
    logic  ucq_ready = 1'b0;
    logic  clear = 1'b0;
    logic  conflict;
`ifdef BCP_STATS_EN
    logic [31:0] nodes_visited;
    logic [31:0] implications;
`endif

    node_t mem [16];
    assign node_out = mem[cnf_idx];

    bcp_engine #(.DEPTH(16), .MAX_WALK(MAXW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ucarb2bcp_lit          (lit),
        .ucarb2bcp_lit_valid    (lit_valid),
        .bcp2ucarb_ready        (ready),
        .clq2bcp_init_ptr       (init_ptr),
        .clq2bcp_init_ptr_valid (init_ptr_valid),
        .bcp2clq_cnf_idx        (cnf_idx),
        .clq2bcp_node_out       (node_out),
        .bcp2ucq_lit            (ucq_lit),
        .bcp2ucq_valid          (ucq_valid),
        .ucq2bcp_ready          (ucq_ready),
        .top2bcp_clear          (clear),
        .bcp2top_conflict       (conflict)
`ifdef BCP_STATS_EN
        ,
        .bcp2top_nodes_visited  (nodes_visited),
        .bcp2top_implications   (implications)
`endif
    );

    always #5 clk = ~clk;

    int   ncmp = 0;
    int   nfail = 0;
    bit   m_asg [17];
    bit   m_val [17];
    lit_t exp_q [$];
    lit_t got_q [$];
    bit   exp_conf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic node_t mk(int a, int b, int c, int nxt, bit last);
        node_t n;
        n.lit0 = lit_t'(a);
        n.lit1 = lit_t'(b);
        n.lit2 = lit_t'(c);
        n.next = ptr_t'(nxt);
        n.last = last;
        return n;
    endfunction

    function automatic lit_t rand_lit();
        int v = int'($urandom_range(1, 6));
        return ($urandom_range(0, 1) != 0) ? lit_t'(-v) : lit_t'(v);
    endfunction

    function automatic void model_zero();
        for (int i = 0; i < 17; i++) begin
            m_asg[i] = 1'b0;
            m_val[i] = 1'b0;
        end
    endfunction

    // Record an asserted literal; returns 1 when it contradicts an earlier one.
    function automatic bit model_apply(lit_t l);
        int v = (int'(l) < 0) ? -int'(l) : int'(l);
        bit pos = int'(l) > 0;
        if (v == 0) return 1'b0;
        if (m_asg[v] && (m_val[v] != pos)) return 1'b1;
        m_asg[v] = 1'b1;
        m_val[v] = pos;
        return 1'b0;
    endfunction

    // Walk the occurrence list from p and list the implications / conflict expected.
    function automatic void model_walk(ptr_t p);
        ptr_t q = p;
        exp_q.delete();
        exp_conf = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            node_t n = mem[q];
            lit_t  ls [3];
            bit    sat = 1'b0;
            int    unas = 0;
            lit_t  ul = '0;
            ls[0] = n.lit0;
            ls[1] = n.lit1;
            ls[2] = n.lit2;
            for (int s = 0; s < 3; s++) begin
                int v = (int'(ls[s]) < 0) ? -int'(ls[s]) : int'(ls[s]);
                if (v != 0) begin
                    if (!m_asg[v]) begin
                        unas++;
                        ul = ls[s];
                    end else if (m_val[v] == (int'(ls[s]) > 0)) begin
                        sat = 1'b1;
                    end
                end
            end
            if (!sat && unas == 0) begin
                exp_conf = 1'b1;
                break;
            end
            if (!sat && unas == 1) exp_q.push_back(ul);
            if (n.last) break;
            q = n.next;
        end
    endfunction

    task automatic offer(input lit_t l, input ptr_t p, input logic pv);
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk("offer_ready", {31'd0, ready}, 32'd1);
        lit = l;
        init_ptr = p;
        init_ptr_valid = pv;
        lit_valid = 1'b1;
        tick();
        lit_valid = 1'b0;
        init_ptr_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
    endtask

    // Run a walk to completion with random back-pressure, collecting pushes.
    task automatic run_collect(input int budget);
        bit   prev_stall = 1'b0;
        lit_t prev_lit = '0;
        bit   done = 1'b0;
        got_q.delete();
        for (int n = 0; n < budget && !done; n++) begin
            ucq_ready = ($urandom_range(0, 2) != 0);
            if (prev_stall) begin
                chk("emit_hold_valid", {31'd0, ucq_valid}, 32'd1);
                chk("emit_hold_lit", ucq_lit, prev_lit);
            end
            if (ucq_valid && ucq_ready) got_q.push_back(ucq_lit);
            prev_stall = ucq_valid && !ucq_ready;
            prev_lit = ucq_lit;
            tick();
            if (ready || conflict) done = 1'b1;
        end
        ucq_ready = 1'b0;
        chk("walk_done_in_budget", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   mc;
        lit_t l;
        ptr_t p;
        for (int i = 0; i < 16; i++) mem[i] = mk(0, 0, 0, 0, 1);
        model_zero();

        // Reset values while held in reset, then ready after release.
        #13;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_valid", {31'd0, ucq_valid}, 32'd0);
        chk("rst_lit", ucq_lit, 32'd0);
        chk("rst_idx", cnf_idx, 32'd0);
        chk("rst_conflict", {31'd0, conflict}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, ready}, 32'd1);

        // Satisfied clause: no push, back to IDLE after two cycles.
        mem[3] = mk(3, -4, 0, 0, 1);
        offer(lit_t'(3), ptr_t'(3), 1'b1);
        chk("sat_walk_idx", cnf_idx, 32'd3);
        chk("sat_walk_ready", {31'd0, ready}, 32'd0);
        chk("sat_walk_valid", {31'd0, ucq_valid}, 32'd0);
        tick();
        chk("sat_idle_ready", {31'd0, ready}, 32'd1);
        chk("sat_idle_valid", {31'd0, ucq_valid}, 32'd0);
        chk("sat_conflict", {31'd0, conflict}, 32'd0);

        // Unit clause: push +2 held under back-pressure.
        do_clear();
        offer(lit_t'(-4), ptr_t'(0), 1'b0);
        mem[6] = mk(-5, 4, 2, 0, 1);
        offer(lit_t'(5), ptr_t'(6), 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("unit_valid_held", {31'd0, ucq_valid}, 32'd1);
            chk("unit_lit", ucq_lit, lit_t'(2));
            chk("unit_ready_low", {31'd0, ready}, 32'd0);
            tick();
        end
        ucq_ready = 1'b1;
        tick();
        ucq_ready = 1'b0;
        chk("unit_valid_drop", {31'd0, ucq_valid}, 32'd0);
        chk("unit_ready_back", {31'd0, ready}, 32'd1);

        // Conflict clause, HALT until clear, table emptied by clear.
        do_clear();
        offer(lit_t'(-1), ptr_t'(0), 1'b0);
        offer(lit_t'(-2), ptr_t'(0), 1'b0);
        mem[7] = mk(1, 2, -3, 0, 1);
        offer(lit_t'(3), ptr_t'(7), 1'b1);
        tick();
        tick();
        chk("conf_flag", {31'd0, conflict}, 32'd1);
        chk("conf_ready", {31'd0, ready}, 32'd0);
        chk("conf_valid", {31'd0, ucq_valid}, 32'd0);
        do_clear();
        chk("conf_cleared", {31'd0, conflict}, 32'd0);
        chk("conf_clear_ready", {31'd0, ready}, 32'd1);
        offer(lit_t'(1), ptr_t'(0), 1'b0);
        chk("table_cleared", {31'd0, conflict}, 32'd0);
        offer(lit_t'(-1), ptr_t'(0), 1'b0);
        chk("opposite_polarity_conflict", {31'd0, conflict}, 32'd1);
        chk("opposite_polarity_ready", {31'd0, ready}, 32'd0);

        // Three-node list 0 -> 5 -> 9.
        do_clear();
        mem[0] = mk(7, 0, 0, 5, 0);
        mem[5] = mk(7, 0, 0, 9, 0);
        mem[9] = mk(7, 0, 0, 0, 1);
        offer(lit_t'(7), ptr_t'(0), 1'b1);
        chk("list_idx0", cnf_idx, 32'd0);
        tick();
        chk("list_idx5", cnf_idx, 32'd5);
        tick();
        chk("list_idx9", cnf_idx, 32'd9);
        chk("list_busy", {31'd0, ready}, 32'd0);
        tick();
        chk("list_done", {31'd0, ready}, 32'd1);

        // Cyclic list stops after MAX_WALK nodes.
        do_clear();
        mem[0] = mk(7, 0, 0, 1, 0);
        mem[1] = mk(7, 0, 0, 0, 0);
        offer(lit_t'(7), ptr_t'(0), 1'b1);
        for (int i = 0; i < MAXW; i++) begin
            chk("cyc_idx", cnf_idx, i % 2);
            chk("cyc_busy", {31'd0, ready}, 32'd0);
            tick();
        end
        chk("cyc_done", {31'd0, ready}, 32'd1);

        // Randomized walks against the reference model.
        for (int t = 0; t < 40; t++) begin
            do_clear();
            for (int i = 0; i < 16; i++) begin
                mem[i] = mk(($urandom_range(0, 3) == 0) ? 0 : int'(rand_lit()),
                            ($urandom_range(0, 3) == 0) ? 0 : int'(rand_lit()),
                            ($urandom_range(0, 3) == 0) ? 0 : int'(rand_lit()),
                            int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
            end
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
                l = rand_lit();
                mc = model_apply(l);
                offer(l, ptr_t'(0), 1'b0);
                chk("rnd_pre_conflict", {31'd0, conflict}, {31'd0, mc});
                if (conflict || mc) do_clear();
            end
            l = rand_lit();
            p = ptr_t'($urandom_range(0, 15));
            mc = model_apply(l);
            if (mc) begin
                exp_q.delete();
                exp_conf = 1'b1;
            end else begin
                model_walk(p);
            end
            offer(l, p, 1'b1);
            run_collect(200);
            chk("rnd_conflict", {31'd0, conflict}, {31'd0, exp_conf});
            chk("rnd_push_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                chk("rnd_push_lit", got_q[i], exp_q[i]);
            end
        end

        // Reset asserted during EMIT.
        do_clear();
        offer(lit_t'(-4), ptr_t'(0), 1'b0);
        mem[2] = mk(-5, 4, 2, 0, 1);
        offer(lit_t'(5), ptr_t'(2), 1'b1);
        tick();
        chk("pre_rst_emit_valid", {31'd0, ucq_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, ucq_valid}, 32'd0);
        chk("mid_rst_lit", ucq_lit, 32'd0);
        chk("mid_rst_idx", cnf_idx, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        chk("mid_rst_conflict", {31'd0, conflict}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after_rst_ready", {31'd0, ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
